// File: rtl/regfile_read_port.sv
// regfile_read_port: registered 2-deep read response queue over a flat register array.
// Define READ_BYPASS_EN to forward same-cycle write data into the captured read value.
module regfile_read_port #(
   parameter int  WIDTH    = 64,
   parameter int  NUM_REGS = 32,
   parameter int  ZERO_REG = 31,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      rd_valid,
   output logic                      rd_ready,
   input  logic [AW-1:0]             rd_addr,
   input  logic                      wr_en,
   input  logic [AW-1:0]             wr_addr,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic [NUM_REGS*WIDTH-1:0] regs_flat,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [WIDTH-1:0]          rsp_data,
   output logic [AW-1:0]             rsp_addr
);
   logic [1:0]       count_q, count_d, base;
   logic             live_q;
   logic [WIDTH-1:0] data_q [2];
   logic [WIDTH-1:0] data_d [2];
   logic [AW-1:0]    addr_q [2];
   logic [AW-1:0]    addr_d [2];
   logic [WIDTH-1:0] slice, cap;
   logic             acc, pop;

   assign rd_ready  = live_q & (count_q != 2'd2);
   assign rsp_valid = count_q != 2'd0;
   assign rsp_data  = rsp_valid ? data_q[0] : '0;
   assign rsp_addr  = rsp_valid ? addr_q[0] : '0;
   assign acc       = rd_valid & rd_ready;
   assign pop       = rsp_valid & rsp_ready;

`ifndef READ_BYPASS_EN
   logic unused_wr;
   assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

   // Out-of-range indices match no slice and read as zero.
   always_comb begin
      slice = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (rd_addr == AW'(i)) slice = regs_flat[i*WIDTH +: WIDTH];
      cap = (rd_addr == AW'(ZERO_REG)) ? '0 : slice;
`ifdef READ_BYPASS_EN
      if (wr_en && wr_addr == rd_addr && rd_addr != AW'(ZERO_REG)) cap = wr_data;
`endif
   end

   // Pop shifts entry 1 into the head; the new entry lands right behind the survivors.
   always_comb begin
      data_d[0] = pop ? data_q[1] : data_q[0];
      data_d[1] = pop ? '0 : data_q[1];
      addr_d[0] = pop ? addr_q[1] : addr_q[0];
      addr_d[1] = pop ? '0 : addr_q[1];
      base      = count_q - {1'b0, pop};
      if (acc) begin
         data_d[base[0]] = cap;
         addr_d[base[0]] = rd_addr;
      end
      count_d = base + {1'b0, acc};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
         live_q  <= 1'b0;
         data_q  <= '{default: '0};
         addr_q  <= '{default: '0};
      end else begin
         count_q <= count_d;
         live_q  <= 1'b1;
         data_q  <= data_d;
         addr_q  <= addr_d;
      end
   end
endmodule

// File: tb/tb_regfile_read_port.sv
// tb_regfile_read_port: directed checks of the read port queue, zero register and bypass.
module tb_regfile_read_port;
   logic          clk, reset_n, rd_valid, rd_ready, wr_en, rsp_valid, rsp_ready;
   logic [4:0]    rd_addr, wr_addr, rsp_addr;
   logic [63:0]   wr_data, rsp_data;
   logic [2047:0] regs_flat;
   logic [63:0]   regs [32];
   int            n_checks = 0, n_fail = 0;

   regfile_read_port dut (
      .clk(clk), .reset_n(reset_n), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .regs_flat(regs_flat), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_addr(rsp_addr)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always_comb
      for (int i = 0; i < 32; i++) regs_flat[i*64 +: 64] = regs[i];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = {32'hC0DE_0000 + 32'(i), 32'h1000_0000 + 32'(i)};
      reset_n = 0; rd_valid = 0; rd_addr = 0; wr_en = 0; wr_addr = 0; wr_data = 0; rsp_ready = 0;
      step; step;
      check("rst_valid", 64'(rsp_valid), 0);
      check("rst_ready", 64'(rd_ready), 0);
      check("rst_data", rsp_data, 0);
      check("rst_addr", 64'(rsp_addr), 0);
      reset_n = 1;
      #1 check("rel_ready_pre", 64'(rd_ready), 0);
      step;
      check("rel_ready", 64'(rd_ready), 1);

      // single read
      regs[5] = 64'hDEAD_BEEF_0000_0005;
      rd_valid = 1; rd_addr = 5; rsp_ready = 1;
      step; rd_valid = 0;
      check("single_valid", 64'(rsp_valid), 1);
      check("single_data", rsp_data, 64'hDEAD_BEEF_0000_0005);
      check("single_addr", 64'(rsp_addr), 5);
      step;
      check("single_empty", 64'(rsp_valid), 0);
      check("single_zero", rsp_data, 0);

      // backpressure
      rsp_ready = 0; rd_valid = 1; rd_addr = 1;
      step;
      check("bp_ready1", 64'(rd_ready), 1);
      rd_addr = 2;
      step;
      check("bp_full", 64'(rd_ready), 0);
      rd_addr = 3;
      step;
      check("bp_hold_ready", 64'(rd_ready), 0);
      check("bp_hold_data", rsp_data, regs[1]);
      check("bp_hold_addr", 64'(rsp_addr), 1);
      rsp_ready = 1;
      step;
      check("bp_x2_addr", 64'(rsp_addr), 2);
      check("bp_x2_data", rsp_data, regs[2]);
      step; rd_valid = 0;
      check("bp_x3_addr", 64'(rsp_addr), 3);
      check("bp_x3_data", rsp_data, regs[3]);
      step;
      check("bp_empty", 64'(rsp_valid), 0);

      // zero register, with a same-cycle write to it
      regs[31] = '1;
      rd_valid = 1; rd_addr = 31; wr_en = 1; wr_addr = 31; wr_data = 64'h123;
      step; rd_valid = 0; wr_en = 0;
      check("zr_valid", 64'(rsp_valid), 1);
      check("zr_data", rsp_data, 0);
      check("zr_addr", 64'(rsp_addr), 31);
      step;
      check("zr_empty", 64'(rsp_valid), 0);

      // same-cycle read/write of X7, then a later write must not touch the queued entry
      regs[7] = 64'h1; rsp_ready = 0;
      rd_valid = 1; rd_addr = 7; wr_en = 1; wr_addr = 7; wr_data = 64'h2;
      step; regs[7] = 64'h2; rd_valid = 0; wr_data = 64'h3;
      step; regs[7] = 64'h3; wr_en = 0;
`ifdef READ_BYPASS_EN
      check("byp_data", rsp_data, 64'h2);
`else
      check("byp_data", rsp_data, 64'h1);
`endif
      check("byp_addr", 64'(rsp_addr), 7);
      rsp_ready = 1;
      step;
      check("byp_empty", 64'(rsp_valid), 0);

      // throughput: one response per cycle
      rd_valid = 1;
      for (int i = 0; i < 31; i++) begin
         rd_addr = 5'(i);
         step;
         check($sformatf("tp_ready%0d", i), 64'(rd_ready), 1);
         check($sformatf("tp_valid%0d", i), 64'(rsp_valid), 1);
         check($sformatf("tp_addr%0d", i), 64'(rsp_addr), 64'(i));
         check($sformatf("tp_data%0d", i), rsp_data, regs[i]);
      end
      rd_valid = 0;
      step;
      check("tp_empty", 64'(rsp_valid), 0);

      // reset with the queue full
      rsp_ready = 0; rd_valid = 1; rd_addr = 1;
      step; rd_addr = 2;
      step; rd_valid = 0;
      check("mid_full", 64'(rd_ready), 0);
      reset_n = 0;
      #1;
      check("mid_rst_valid", 64'(rsp_valid), 0);
      check("mid_rst_ready", 64'(rd_ready), 0);
      step; reset_n = 1;
      step;
      check("mid_rel_ready", 64'(rd_ready), 1);
      check("mid_rel_valid", 64'(rsp_valid), 0);
      rsp_ready = 1;
      step;
      check("mid_no_stale", 64'(rsp_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
